// File: rtl/inst_queue.sv
// inst_queue: instruction fetch front-end.
// Holds the fetch PC, keeps at most one fetch outstanding toward the walker,
// buffers returned words in a small FIFO for the core, predicts the next PC
// and flushes on a core redirect.
// Optional feature macro: BRANCH_PREDICT_EN adds a direct-mapped BTB with
// 2-bit counters; without it the prediction is always pc+4.
module inst_queue #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ireq_valid,
    input  logic [XLEN-1:0] ireq_addr,
    output logic            iresp_valid,
    input  logic            iresp_ready,
    output logic [XLEN-1:0] iresp_addr,
    output logic [31:0]     iresp_inst,
    output logic            iresp_error,
    output logic [XLEN-1:0] iresp_pred_next,
    output logic            memreq_valid,
    input  logic            memreq_ready,
    output logic [XLEN-1:0] memreq_addr,
    input  logic            memresp_valid,
    input  logic [31:0]     memresp_rdata,
    input  logic            memresp_error,
    input  logic            brinfo_valid,
    input  logic [XLEN-1:0] brinfo_pc,
    input  logic            brinfo_is_br_jmp,
    input  logic            brinfo_taken,
    input  logic [XLEN-1:0] brinfo_target
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  pc;
    logic             inflight;
    logic [XLEN-1:0]  inflight_addr;
    logic [XLEN-1:0]  inflight_pred;
    logic             discard;
    logic             halted;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;

    logic [XLEN-1:0]  fifo_addr  [DEPTH];
    logic [31:0]      fifo_inst  [DEPTH];
    logic             fifo_error [DEPTH];
    logic [XLEN-1:0]  fifo_pred  [DEPTH];

    logic             fire;
    logic             resp;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  pred;

    // The outstanding fetch reserves a FIFO slot, so a response can never overflow.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

    // Request is held low while reset is asserted so every output reads 0.
    assign memreq_valid = rst_n & ~inflight & ~halted & ~ireq_valid
                        & (occupancy < (CNT_W + 1)'(DEPTH));
    assign memreq_addr  = pc;

    assign iresp_valid     = (count != '0) & ~ireq_valid;
    assign iresp_addr      = fifo_addr[rd_ptr];
    assign iresp_inst      = fifo_inst[rd_ptr];
    assign iresp_error     = fifo_error[rd_ptr];
    assign iresp_pred_next = fifo_pred[rd_ptr];

    assign fire = memreq_valid & memreq_ready;
    assign resp = memresp_valid & inflight;
    assign push = resp & ~discard & ~ireq_valid;
    assign pop  = iresp_valid & iresp_ready;

`ifdef BRANCH_PREDICT_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] br_idx;
    logic [TAG_W-1:0] br_tag;
    logic             br_update;
    logic             br_hit;
    logic             unused_br_bits;

    assign pc_idx = pc[IDX_W+1:2];
    assign pc_tag = pc[XLEN-1:IDX_W+2];
    assign br_idx = brinfo_pc[IDX_W+1:2];
    assign br_tag = brinfo_pc[XLEN-1:IDX_W+2];

    // Taken prediction needs a tag hit and a counter in the upper half.
    assign pred = (btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag) && btb_ctr[pc_idx][1])
                ? btb_target[pc_idx] : pc + XLEN'(4);

    assign br_update      = brinfo_valid & brinfo_is_br_jmp;
    assign br_hit         = btb_valid[br_idx] && (btb_tag[br_idx] == br_tag);
    assign unused_br_bits = ^brinfo_pc[1:0];

    // BTB valid bits: cleared on reset, set on allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
        end else if (br_update) begin
            btb_valid[br_idx] <= 1'b1;
        end
    end

    // BTB payload: tag, target and saturating direction counter.
    // NOTE: payload is not reset; the valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        if (br_update) begin
            btb_tag[br_idx]    <= br_tag;
            btb_target[br_idx] <= brinfo_target;
            if (br_hit) begin
                if (brinfo_taken)
                    btb_ctr[br_idx] <= (btb_ctr[br_idx] == 2'd3) ? 2'd3 : btb_ctr[br_idx] + 2'd1;
                else
                    btb_ctr[br_idx] <= (btb_ctr[br_idx] == 2'd0) ? 2'd0 : btb_ctr[br_idx] - 2'd1;
            end else begin
                btb_ctr[br_idx] <= brinfo_taken ? 2'd2 : 2'd1;
            end
        end
    end
`else
    logic unused_brinfo;

    assign pred          = pc + XLEN'(4);
    assign unused_brinfo = ^{brinfo_valid, brinfo_pc, brinfo_is_br_jmp, brinfo_taken, brinfo_target};
`endif

    // Fetch state, outstanding-request tracking and the instruction FIFO.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            inflight_pred <= '0;
            discard       <= 1'b0;
            halted        <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            // NOTE: the FIFO payload is reset because the head drives the
            // iresp_* outputs directly and they must read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr[i]  <= '0;
                fifo_inst[i]  <= '0;
                fifo_error[i] <= 1'b0;
                fifo_pred[i]  <= '0;
            end
        end else if (ireq_valid) begin
            // Redirect: flush everything and restart at the target.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= ireq_addr;
            halted <= 1'b0;
            if (resp) begin
                inflight <= 1'b0;
                discard  <= 1'b0;
            end else if (inflight) begin
                discard <= 1'b1;
            end
        end else begin
            if (fire) begin
                inflight      <= 1'b1;
                inflight_addr <= pc;
                inflight_pred <= pred;
                pc            <= pred;
            end
            if (resp) begin
                inflight <= 1'b0;
                if (discard)
                    discard <= 1'b0;
                else if (memresp_error)
                    halted <= 1'b1;
            end
            if (push) begin
                fifo_addr[wr_ptr]  <= inflight_addr;
                fifo_inst[wr_ptr]  <= memresp_rdata;
                fifo_error[wr_ptr] <= memresp_error;
                fifo_pred[wr_ptr]  <= inflight_pred;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue: reference vectors, directed corner sequences and
// randomized traffic checked against a queue-based model of the fetch rules.
module tb_inst_queue;

    localparam int          XLEN        = 32;
    localparam int          DEPTH       = 4;
    localparam logic [31:0] RESET_PC    = 32'h0;
    localparam int          BTB_ENTRIES = 16;
    localparam int          IDX_W       = $clog2(BTB_ENTRIES);

    logic        clk;
    logic        rst_n;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic        iresp_ready;
    logic [31:0] iresp_addr;
    logic [31:0] iresp_inst;
    logic        iresp_error;
    logic [31:0] iresp_pred_next;
    logic        memreq_valid;
    logic        memreq_ready;
    logic [31:0] memreq_addr;
    logic        memresp_valid;
    logic [31:0] memresp_rdata;
    logic        memresp_error;
    logic        brinfo_valid;
    logic [31:0] brinfo_pc;
    logic        brinfo_is_br_jmp;
    logic        brinfo_taken;
    logic [31:0] brinfo_target;

    inst_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .BTB_ENTRIES(BTB_ENTRIES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_valid(iresp_valid), .iresp_ready(iresp_ready),
        .iresp_addr(iresp_addr), .iresp_inst(iresp_inst),
        .iresp_error(iresp_error), .iresp_pred_next(iresp_pred_next),
        .memreq_valid(memreq_valid), .memreq_ready(memreq_ready), .memreq_addr(memreq_addr),
        .memresp_valid(memresp_valid), .memresp_rdata(memresp_rdata), .memresp_error(memresp_error),
        .brinfo_valid(brinfo_valid), .brinfo_pc(brinfo_pc), .brinfo_is_br_jmp(brinfo_is_br_jmp),
        .brinfo_taken(brinfo_taken), .brinfo_target(brinfo_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
        logic [31:0] pred;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc, m_iaddr, m_ipred;
    bit          m_inflight, m_discard, m_halted;
    bit          b_valid [BTB_ENTRIES];
    logic [31:0] b_tag   [BTB_ENTRIES];
    logic [31:0] b_tgt   [BTB_ENTRIES];
    int          b_ctr   [BTB_ENTRIES];

    // Memory responder helpers for the directed sequences.
    bit          err_en;
    logic [31:0] err_addr;

    task automatic model_reset();
        q.delete();
        m_pc = RESET_PC; m_iaddr = '0; m_ipred = '0;
        m_inflight = 0; m_discard = 0; m_halted = 0;
        for (int i = 0; i < BTB_ENTRIES; i++) b_valid[i] = 0;
    endtask

    function automatic logic [31:0] m_predict(input logic [31:0] pc);
`ifdef BRANCH_PREDICT_EN
        int idx;
        idx = int'((pc >> 2) % 32'(BTB_ENTRIES));
        if (b_valid[idx] && b_tag[idx] == (pc >> (IDX_W + 2)) && b_ctr[idx] >= 2)
            return b_tgt[idx];
`endif
        return pc + 32'd4;
    endfunction

    // Compare DUT outputs with the model for the current cycle, then advance the model.
    task automatic model_step();
        bit          e_mv, e_iv, fire, pop, resp;
        logic [31:0] pred;
        e_mv = !m_inflight && !m_halted && !ireq_valid && (q.size() + int'(m_inflight) < DEPTH);
        e_iv = (q.size() != 0) && !ireq_valid;
        check("model memreq_valid", 32'(memreq_valid), 32'(e_mv));
        check("model memreq_addr", memreq_addr, m_pc);
        check("model iresp_valid", 32'(iresp_valid), 32'(e_iv));
        if (e_iv) begin
            check("model iresp_addr", iresp_addr, q[0].addr);
            check("model iresp_inst", iresp_inst, q[0].inst);
            check("model iresp_error", 32'(iresp_error), 32'(q[0].err));
            check("model iresp_pred_next", iresp_pred_next, q[0].pred);
        end
        fire = e_mv && memreq_ready;
        pop  = e_iv && iresp_ready;
        resp = memresp_valid && m_inflight;
        if (ireq_valid) begin
            q.delete();
            m_pc = ireq_addr;
            m_halted = 0;
            if (resp) begin
                m_inflight = 0; m_discard = 0;
            end else if (m_inflight) begin
                m_discard = 1;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (fire) begin
                pred = m_predict(m_pc);
                m_inflight = 1; m_iaddr = m_pc; m_ipred = pred; m_pc = pred;
            end else if (resp) begin
                m_inflight = 0;
                if (m_discard) m_discard = 0;
                else begin
                    q.push_back('{addr: m_iaddr, inst: memresp_rdata, err: memresp_error, pred: m_ipred});
                    if (memresp_error) m_halted = 1;
                end
            end
        end
`ifdef BRANCH_PREDICT_EN
        if (brinfo_valid && brinfo_is_br_jmp) begin
            int idx;
            idx = int'((brinfo_pc >> 2) % 32'(BTB_ENTRIES));
            if (b_valid[idx] && b_tag[idx] == (brinfo_pc >> (IDX_W + 2))) begin
                b_ctr[idx] = brinfo_taken ? ((b_ctr[idx] < 3) ? b_ctr[idx] + 1 : 3)
                                          : ((b_ctr[idx] > 0) ? b_ctr[idx] - 1 : 0);
            end else begin
                b_valid[idx] = 1;
                b_tag[idx]   = brinfo_pc >> (IDX_W + 2);
                b_ctr[idx]   = brinfo_taken ? 2 : 1;
            end
            b_tgt[idx] = brinfo_target;
        end
`endif
    endtask

    // One clock: inputs were set at posedge+1 by the caller.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle memory: answer the cycle after acceptance.
    task automatic drive_auto();
        memresp_valid = m_inflight;
        memresp_rdata = m_iaddr ^ 32'h1357_9bdf;
        memresp_error = err_en && (m_iaddr == err_addr);
    endtask

    task automatic clear_inputs();
        ireq_valid = 0; ireq_addr = '0; iresp_ready = 0; memreq_ready = 0;
        memresp_valid = 0; memresp_rdata = '0; memresp_error = 0;
        brinfo_valid = 0; brinfo_pc = '0; brinfo_is_br_jmp = 0; brinfo_taken = 0; brinfo_target = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        mr_ready;
        logic        rsp_valid;
        logic [31:0] rdata;
        logic        ir_ready;
        logic        e_mvalid;
        logic [31:0] e_maddr;
        logic        e_ivalid;
        logic [31:0] e_iaddr;
        logic [31:0] e_inst;
        logic [31:0] e_pred;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fires;
        bit  found;
        err_en = 0; err_addr = '0;

        // Basic in-order fetch with a one-cycle memory and a ready core.
        vecs[0] = '{1, 0, 32'h0,         1, 1, 32'h0, 0, 32'h0, 32'h0,         32'h0};
        vecs[1] = '{1, 1, 32'hAAAA_0000, 1, 0, 32'h4, 0, 32'h0, 32'h0,         32'h0};
        vecs[2] = '{1, 0, 32'h0,         1, 1, 32'h4, 1, 32'h0, 32'hAAAA_0000, 32'h4};
        vecs[3] = '{1, 1, 32'hBBBB_0004, 1, 0, 32'h8, 0, 32'h0, 32'h0,         32'h0};
        vecs[4] = '{1, 0, 32'h0,         1, 1, 32'h8, 1, 32'h4, 32'hBBBB_0004, 32'h8};
        vecs[5] = '{1, 1, 32'hCCCC_0008, 1, 0, 32'hC, 0, 32'h0, 32'h0,         32'h0};
        vecs[6] = '{0, 0, 32'h0,         1, 1, 32'hC, 1, 32'h8, 32'hCCCC_0008, 32'hC};

        // Reset state, sampled while rst_n is still low.
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #3;
        check("reset memreq_valid", 32'(memreq_valid), 32'h0);
        check("reset memreq_addr", memreq_addr, RESET_PC);
        check("reset iresp_valid", 32'(iresp_valid), 32'h0);
        check("reset iresp_addr", iresp_addr, 32'h0);
        check("reset iresp_pred_next", iresp_pred_next, 32'h0);
        reset_dut();

        for (int i = 0; i < 7; i++) begin
            memreq_ready  = vecs[i].mr_ready;
            memresp_valid = vecs[i].rsp_valid;
            memresp_rdata = vecs[i].rdata;
            memresp_error = 0;
            iresp_ready   = vecs[i].ir_ready;
            #1;
            check($sformatf("vec%0d memreq_valid", i), 32'(memreq_valid), 32'(vecs[i].e_mvalid));
            check($sformatf("vec%0d memreq_addr", i), memreq_addr, vecs[i].e_maddr);
            check($sformatf("vec%0d iresp_valid", i), 32'(iresp_valid), 32'(vecs[i].e_ivalid));
            if (vecs[i].e_ivalid) begin
                check($sformatf("vec%0d iresp_addr", i), iresp_addr, vecs[i].e_iaddr);
                check($sformatf("vec%0d iresp_inst", i), iresp_inst, vecs[i].e_inst);
                check($sformatf("vec%0d iresp_pred_next", i), iresp_pred_next, vecs[i].e_pred);
            end
            tick();
        end

        // Backpressure: exactly DEPTH fetches, then one more per pop.
        reset_dut();
        memreq_ready = 1;
        fires = 0;
        for (int c = 0; c < 20; c++) begin
            drive_auto(); #1;
            if (memreq_valid) fires++;
            tick();
        end
        check("backpressure fetch count", 32'(fires), 32'(DEPTH));
        drive_auto(); #1;
        check("backpressure memreq_valid held low", 32'(memreq_valid), 32'h0);
        check("backpressure head addr", iresp_addr, 32'h0);
        iresp_ready = 1;
        tick();
        iresp_ready = 0;
        fires = 0;
        for (int c = 0; c < 8; c++) begin
            drive_auto(); #1;
            if (memreq_valid) fires++;
            tick();
        end
        check("backpressure refill count", 32'(fires), 32'h1);

        // Redirect while 0x8 is in flight: its response is discarded.
        reset_dut();
        memreq_ready = 1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            drive_auto(); #1;
            if (memreq_valid && memreq_addr == 32'h8) found = 1;
            tick();
        end
        check("redirect reached fetch of 0x8", 32'(found), 32'h1);
        memresp_valid = 0; ireq_valid = 1; ireq_addr = 32'h100;
        #1;
        check("redirect iresp_valid masked", 32'(iresp_valid), 32'h0);
        tick();
        ireq_valid = 0; memresp_valid = 1; memresp_rdata = 32'hDEAD_0008; memreq_ready = 0;
        #1;
        check("redirect waits for stale response", 32'(memreq_valid), 32'h0);
        check("redirect fifo empty", 32'(iresp_valid), 32'h0);
        tick();
        memresp_valid = 0; memreq_ready = 1;
        #1;
        check("redirect new memreq_valid", 32'(memreq_valid), 32'h1);
        check("redirect new memreq_addr", memreq_addr, 32'h100);
        check("redirect stale entry dropped", 32'(iresp_valid), 32'h0);
        tick();
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            drive_auto(); #1;
            if (iresp_valid) begin
                found = 1;
                check("redirect first iresp_addr", iresp_addr, 32'h100);
            end
            tick();
        end
        check("redirect response arrived", 32'(found), 32'h1);

        // Fetch fault on 0x4: fetching halts until a redirect.
        reset_dut();
        err_en = 1; err_addr = 32'h4; memreq_ready = 1;
        fires = 0;
        for (int c = 0; c < 15; c++) begin
            drive_auto(); #1;
            if (memreq_valid) fires++;
            tick();
        end
        check("error fetch count", 32'(fires), 32'h2);
        drive_auto(); #1;
        check("error halted", 32'(memreq_valid), 32'h0);
        check("error head0 addr", iresp_addr, 32'h0);
        check("error head0 flag", 32'(iresp_error), 32'h0);
        iresp_ready = 1;
        tick();
        iresp_ready = 0; #1;
        check("error head1 valid", 32'(iresp_valid), 32'h1);
        check("error head1 addr", iresp_addr, 32'h4);
        check("error head1 flag", 32'(iresp_error), 32'h1);
        ireq_valid = 1; ireq_addr = 32'h200;
        tick();
        ireq_valid = 0; err_en = 0;
        #1;
        check("error resume memreq_valid", 32'(memreq_valid), 32'h1);
        check("error resume memreq_addr", memreq_addr, 32'h200);
        tick();

`ifdef BRANCH_PREDICT_EN
        // Taken branch at 0x10 trained into the BTB.
        reset_dut();
        brinfo_valid = 1; brinfo_is_br_jmp = 1; brinfo_pc = 32'h10; brinfo_taken = 1; brinfo_target = 32'h40;
        tick();
        brinfo_valid = 0; ireq_valid = 1; ireq_addr = 32'h10;
        tick();
        ireq_valid = 0; memreq_ready = 1; #1;
        check("btb fetch 0x10", memreq_addr, 32'h10);
        tick();
        drive_auto(); memreq_ready = 0; #1;
        tick();
        memresp_valid = 0; #1;
        check("btb next fetch", memreq_addr, 32'h40);
        check("btb iresp_valid", 32'(iresp_valid), 32'h1);
        check("btb pred_next", iresp_pred_next, 32'h40);
        tick();
`endif

        // Asynchronous reset in the middle of a fetch.
        reset_dut();
        memreq_ready = 1;
        for (int c = 0; c < 3; c++) begin
            drive_auto(); #1;
            tick();
        end
        drive_auto(); #1;
        rst_n = 1'b0;
        #1;
        check("async memreq_valid", 32'(memreq_valid), 32'h0);
        check("async memreq_addr", memreq_addr, 32'h0);
        check("async iresp_valid", 32'(iresp_valid), 32'h0);
        check("async iresp_addr", iresp_addr, 32'h0);
        check("async iresp_inst", iresp_inst, 32'h0);
        model_reset();
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        memresp_valid = 1; memresp_rdata = 32'hBAD0_BAD0; memreq_ready = 0;
        #1;
        check("async restart memreq_valid", 32'(memreq_valid), 32'h1);
        check("async restart memreq_addr", memreq_addr, RESET_PC);
        tick();
        memresp_valid = 0; #1;
        check("async stray response ignored", 32'(iresp_valid), 32'h0);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            ireq_valid       = ($urandom_range(0, 29) == 0);
            ireq_addr        = 32'($urandom_range(0, 255)) << 2;
            iresp_ready      = ($urandom_range(0, 2) != 0);
            memreq_ready     = 1'($urandom_range(0, 1));
            memresp_valid    = m_inflight ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            memresp_rdata    = $urandom;
            memresp_error    = ($urandom_range(0, 24) == 0);
            brinfo_valid     = ($urandom_range(0, 3) == 0);
            brinfo_is_br_jmp = ($urandom_range(0, 3) != 0);
            brinfo_pc        = 32'($urandom_range(0, 63)) << 2;
            brinfo_taken     = 1'($urandom_range(0, 1));
            brinfo_target    = 32'($urandom_range(0, 255)) << 2;
            #1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
